mem_arbiter: RTL and testbench

Two-port arbiter sharing the CPU's single synchronous instruction/data memory between the CPU core (fetch, LDW, STW) and an external loader/debug port. Requests use a req/gnt transfer and an ack response. CPU has default priority. A bounded-starvation counter guarantees the external port service while the CPU runs. Sits between the core's memory interface and the memory macro.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry defaults, arbiter state and owner encodings.
// No logic, so no latency or backpressure.
// Imported by the memory arbiter and its starvation counter.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts CPU grants taken while the external port waits; flags when it must win.
// One cycle from inc/clr to cnt/at_max; clear beats increment.
// No backpressure; it saturates at STARVE_MAX instead of wrapping.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       at_max
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between the CPU core and an external loader/debug port.
// Write: strobe and ack one cycle after grant; read: strobe +1, ack and rdata +2.
// Losers keep req high and wait; gnt only in IDLE, CPU favoured but bounded by the starve counter.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_lock,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              lat_we;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;

    logic              at_max;
    logic [3:0]        starve_cnt;
    logic              arb_ok;
    logic              cpu_win;
    logic              ext_win;
    logic              cpu_xfer;
    logic              ext_xfer;
    logic              nxt_we;

    // Lock and starvation both force ext; otherwise the CPU wins any tie.
    assign arb_ok   = (state == IDLE) && !reset;
    assign ext_win  = ext_req && (ext_lock || at_max || !cpu_req);
    assign cpu_win  = cpu_req && !ext_lock && !(at_max && ext_req);
    assign cpu_gnt  = arb_ok && cpu_win;
    assign ext_gnt  = arb_ok && ext_win;
    assign cpu_xfer = cpu_req && cpu_gnt;
    assign ext_xfer = ext_req && ext_gnt;
    assign nxt_we   = ext_xfer ? ext_we : cpu_we;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .CLK    (CLK),
        .reset  (reset),
        .inc    (cpu_xfer && ext_req),
        .clr    (ext_xfer || ((state == IDLE) && !ext_req)),
        .cnt    (starve_cnt),
        .at_max (at_max)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            lat_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wren    <= 1'b0;
            mem_rden    <= 1'b0;
            cpu_ack     <= 1'b0;
            ext_ack     <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            mem_wren <= 1'b0;
            mem_rden <= 1'b0;
            cpu_ack  <= 1'b0;
            ext_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_xfer || ext_xfer) begin
                        owner     <= ext_xfer ? OWN_EXT : OWN_CPU;
                        lat_we    <= nxt_we;
                        mem_addr  <= ext_xfer ? ext_addr : cpu_addr;
                        mem_wdata <= ext_xfer ? ext_wdata : cpu_wdata;
                        mem_wren  <= nxt_we;
                        mem_rden  <= !nxt_we;
                        cpu_ack   <= nxt_we && cpu_xfer;
                        ext_ack   <= nxt_we && ext_xfer;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state <= IDLE;
                    end else begin
                        cpu_ack <= (owner == OWN_CPU);
                        ext_ack <= (owner == OWN_EXT);
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (owner == OWN_CPU) cpu_rdata_q <= mem_q;
                    else                  ext_rdata_q <= mem_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_q is only valid during RESP, so it is forwarded then and held afterwards.
    assign cpu_rdata = ((state == RESP) && (owner == OWN_CPU)) ? mem_q : cpu_rdata_q;
    assign ext_rdata = ((state == RESP) && (owner == OWN_EXT)) ? mem_q : ext_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory behind it.
module tb_mem_arbiter;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_ack;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_gnt, ext_ack, ext_lock;
    logic [7:0]  ext_addr;
    logic [15:0] ext_wdata, ext_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_q;
    logic        mem_wren, mem_rden;

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_MAX(4)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_lock(ext_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_q(mem_q)
    );

    always @(posedge CLK) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ext_load(input logic [7:0] a, input logic [15:0] d);
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        tick();
        ext_req = 1'b0;
        tick();
    endtask

    logic        exp_ext [6];
    logic [3:0]  exp_cnt [6];

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 16'h0;
        ext_lock = 1'b0;
        mem_q = 16'h0;
        tick();
        tick();
        chk("gnt_in_reset", cpu_gnt, 1'b0);
        cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_outputs", {mem_wren, mem_rden, cpu_ack, ext_ack}, 4'b0000);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 24'h0);
        chk("rst_rdata", {cpu_rdata, ext_rdata}, 32'h0);
        chk("rst_state", dut.state, IDLE);
        chk("rst_cnt", dut.u_starve.cnt, 4'd0);

        // Ext write
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h05; ext_wdata = 16'h1234;
        #1;
        chk("ew_gnt", {ext_gnt, cpu_gnt}, 2'b10);
        tick();
        ext_req = 1'b0;
        chk("ew_strobe", {mem_wren, mem_rden, ext_ack, cpu_ack}, 4'b1010);
        chk("ew_addr_data", {mem_addr, mem_wdata}, 24'h05_1234);
        tick();
        chk("ew_done", {mem_wren, ext_ack}, 2'b00);
        chk("ew_idle", dut.state, IDLE);

        ext_load(8'h12, 16'hBEEF);

        // CPU read of 0x12
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        #1;
        chk("cr_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        chk("cr_c1", {mem_rden, mem_wren, cpu_ack, mem_addr}, {3'b100, 8'h12});
        tick();
        chk("cr_c2_ack", {cpu_ack, ext_ack}, 2'b10);
        chk("cr_c2_rdata", cpu_rdata, 16'hBEEF);
        tick();
        chk("cr_c3", {cpu_ack, mem_rden}, 2'b00);
        chk("cr_hold", cpu_rdata, 16'hBEEF);
        chk("cr_ext_rdata", ext_rdata, 16'h0);

        // CPU read-back of the ext write
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("cr05", {cpu_ack, cpu_rdata}, {1'b1, 16'h1234});
        tick();

        // CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'hA5A5;
        #1;
        chk("cw_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        chk("cw_c1", {mem_wren, cpu_ack, ext_ack, mem_addr, mem_wdata}, {3'b110, 8'h20, 16'hA5A5});
        tick();
        chk("cw_c2", {mem_wren, cpu_ack}, 2'b00);

        // Contention with both reading and holding req: four CPU grants then one ext
        exp_ext = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h12;
        #1;
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("ct_gnt%0d", g), {ext_gnt, cpu_gnt}, {exp_ext[g], !exp_ext[g]});
            chk($sformatf("ct_cnt%0d", g), dut.u_starve.cnt, exp_cnt[g]);
            tick();
            chk($sformatf("ct_nognt%0d", g), {ext_gnt, cpu_gnt}, 2'b00);
            tick();
            if (exp_ext[g])
                chk($sformatf("ct_ext_ack%0d", g), {ext_ack, cpu_ack, ext_rdata}, {2'b10, 16'hBEEF});
            else
                chk($sformatf("ct_cpu_ack%0d", g), {ext_ack, cpu_ack, cpu_rdata}, {2'b01, 16'h1234});
            tick();
        end
        chk("ct_cnt_after", dut.u_starve.cnt, 4'd1);

        // Lock: ext only, even when the CPU alone is requesting
        ext_lock = 1'b1;
        #1;
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("lk_gnt%0d", r), {ext_gnt, cpu_gnt}, 2'b10);
            tick();
            tick();
            chk($sformatf("lk_ack%0d", r), {ext_ack, cpu_ack}, 2'b10);
            tick();
        end
        chk("lk_cnt_clr", dut.u_starve.cnt, 4'd0);
        ext_req = 1'b0;
        #1;
        chk("lk_cpu_only", {ext_gnt, cpu_gnt}, 2'b00);
        tick();
        chk("lk_cpu_still", cpu_gnt, 1'b0);
        ext_lock = 1'b0;
        #1;
        chk("lk_release", cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        ext_lock = 1'b1;  // rising during an in-flight CPU read must not abort it
        tick();
        chk("lk_inflight", {cpu_ack, cpu_rdata}, {1'b1, 16'h1234});
        tick();
        ext_lock = 1'b0;

        // Reset in ACCESS of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        #1;
        chk("rr_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        chk("rr_access", {mem_rden, dut.state}, {1'b1, ACCESS});
        reset = 1'b1;
        tick();
        chk("rr_strobes", {cpu_ack, ext_ack, mem_rden, mem_wren}, 4'b0000);
        chk("rr_state_cnt", {dut.state, dut.u_starve.cnt}, {IDLE, 4'd0});
        chk("rr_regs", {mem_addr, mem_wdata, cpu_rdata, ext_rdata}, 56'h0);
        reset = 1'b0;
        tick();
        chk("rr_no_ack", {cpu_ack, mem_rden}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
